// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with 2-FF input synchroniser,
// start-bit glitch rejection, optional parity and 1 or 2 stop bits.
// Emits one o_Rx_DV pulse per character; o_Rx_Byte and error flags hold
// until the next character completes.
// Optional: define UART_RX_BREAK_DET_EN to add the o_Break output.
`timescale 1ns/1ps
module uart_rx_param #(
   parameter int CLKS_PER_BIT = 87,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 i_Clock,
   input  logic                 i_Reset,
   input  logic                 i_Rx_Serial,
   output logic                 o_Rx_DV,
   output logic [DATA_BITS-1:0] o_Rx_Byte,
   output logic                 o_Parity_Err,
   output logic                 o_Frame_Err,
   output logic                 o_Rx_Busy
`ifdef UART_RX_BREAK_DET_EN
   ,
   output logic                 o_Break
`endif
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = 4;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP, CLEANUP, WAIT_HIGH
   } state_t;

   state_t               state, state_nxt;
   logic                 rx_meta, rx_s;
   logic [CNT_W-1:0]     clk_cnt, clk_cnt_nxt;
   logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
   logic [DATA_BITS-1:0] shift_reg, shift_nxt;
   logic                 par_bit, par_nxt;
   logic                 ferr_acc, ferr_nxt;
   logic                 perr_nxt;
   logic                 cnt_done;

   assign cnt_done  = (clk_cnt == CNT_LAST);
   assign o_Rx_DV   = (state == CLEANUP);
   assign o_Rx_Busy = (state != IDLE);

   // Two-flop synchroniser for the asynchronous serial input (idle high)
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= i_Rx_Serial;
         rx_s    <= rx_meta;
      end
   end

   // FSM state, bit-timing counter, bit index and per-character accumulators
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state     <= IDLE;
         clk_cnt   <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         par_bit   <= 1'b0;
         ferr_acc  <= 1'b0;
      end else begin
         state     <= state_nxt;
         clk_cnt   <= clk_cnt_nxt;
         bit_idx   <= bit_idx_nxt;
         shift_reg <= shift_nxt;
         par_bit   <= par_nxt;
         ferr_acc  <= ferr_nxt;
      end
   end

   // Next-state logic: sample each bit at the end of its counted period
   always_comb begin
      state_nxt   = state;
      clk_cnt_nxt = clk_cnt;
      bit_idx_nxt = bit_idx;
      shift_nxt   = shift_reg;
      par_nxt     = par_bit;
      ferr_nxt    = ferr_acc;
      case (state)
         IDLE: begin
            clk_cnt_nxt = '0;
            bit_idx_nxt = '0;
            if (!rx_s) begin
               ferr_nxt  = 1'b0;
               state_nxt = START;
            end
         end
         START: begin
            if (clk_cnt == CNT_HALF) begin
               clk_cnt_nxt = '0;
               state_nxt   = rx_s ? IDLE : DATA;
            end else begin
               clk_cnt_nxt = clk_cnt + 1'b1;
            end
         end
         DATA: begin
            if (cnt_done) begin
               clk_cnt_nxt = '0;
               for (int unsigned i = 0; i < DATA_BITS; i++) begin
                  if (bit_idx == IDX_W'(i)) shift_nxt[i] = rx_s;
               end
               if (bit_idx == DATA_LAST) begin
                  bit_idx_nxt = '0;
                  state_nxt   = (PARITY_MODE != 0) ? PARITY : STOP;
               end else begin
                  bit_idx_nxt = bit_idx + 1'b1;
               end
            end else begin
               clk_cnt_nxt = clk_cnt + 1'b1;
            end
         end
         PARITY: begin
            if (cnt_done) begin
               clk_cnt_nxt = '0;
               par_nxt     = rx_s;
               state_nxt   = STOP;
            end else begin
               clk_cnt_nxt = clk_cnt + 1'b1;
            end
         end
         STOP: begin
            if (cnt_done) begin
               clk_cnt_nxt = '0;
               if (!rx_s) ferr_nxt = 1'b1;
               if (bit_idx == STOP_LAST) begin
                  bit_idx_nxt = '0;
                  state_nxt   = CLEANUP;
               end else begin
                  bit_idx_nxt = bit_idx + 1'b1;
               end
            end else begin
               clk_cnt_nxt = clk_cnt + 1'b1;
            end
         end
         CLEANUP: begin
            state_nxt = ferr_acc ? WAIT_HIGH : IDLE;
         end
         WAIT_HIGH: begin
            if (rx_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Parity check over the character as it will be delivered
   always_comb begin
      perr_nxt = 1'b0;
      if (PARITY_MODE == 1)      perr_nxt = ~(^shift_nxt ^ par_nxt);
      else if (PARITY_MODE == 2) perr_nxt = ^shift_nxt ^ par_nxt;
   end

   // Output registers load on entry to CLEANUP so they are valid with o_Rx_DV
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         o_Rx_Byte    <= '0;
         o_Parity_Err <= 1'b0;
         o_Frame_Err  <= 1'b0;
      end else if (state_nxt == CLEANUP) begin
         o_Rx_Byte    <= shift_nxt;
         o_Parity_Err <= perr_nxt;
         o_Frame_Err  <= ferr_nxt;
      end
   end

`ifdef UART_RX_BREAK_DET_EN
   // Break flag: all-zero character with framing error, held until line idles
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         o_Break <= 1'b0;
      end else if (state_nxt == CLEANUP) begin
         o_Break <= (shift_nxt == '0) && ((PARITY_MODE == 0) || !par_nxt) && ferr_nxt;
      end else if ((state == WAIT_HIGH) && rx_s) begin
         o_Break <= 1'b0;
      end
   end
`endif

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, the next generation of the basic fixed 8N1 receiver. It adds:
- configurable data width, parity mode and stop-bit count
- a 2-FF input synchroniser
- start-bit glitch rejection
- parity and framing error reporting

It sits between the external serial pin and the byte-level command/packet logic. It produces one valid pulse per received character.

Parameters:
CLKS_PER_BIT, 87, clocks per bit (i_Clock freq / baud); legal range is 4 or more
DATA_BITS, 8, data bits per character; legal range is 5..9
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits expected; legal values are 1 or 2

Ports:
i_Clock  in  1  system clock; all logic is on the rising edge
i_Reset  in  1  asynchronous, active-high reset
i_Rx_Serial  in  1  serial line, asynchronous to i_Clock, idle high
o_Rx_DV  out  1  one-cycle pulse: character complete
o_Rx_Byte  out  DATA_BITS  received data, LSB first on the line
o_Parity_Err  out  1  parity mismatch for the last character; held until next o_Rx_DV
o_Frame_Err  out  1  a stop bit sampled low for the last character; held until next o_Rx_DV
o_Rx_Busy  out  1  high whenever state is not IDLE
o_Break  out  1  break detected (present only with UART_RX_BREAK_DET_EN)

Behaviour:
- Reset, asynchronous and active-high:
  - both synchroniser flops go to 1
  - state goes to IDLE; clock counter and bit index go to 0
  - o_Rx_DV, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Rx_Busy and o_Break all go to 0
  - reset mid-frame abandons the character silently; no o_Rx_DV is issued
- Synchroniser: i_Rx_Serial passes through 2 flops. All FSM decisions use the second flop (rx_s). Input-to-decision latency is 2 cycles.
- States: IDLE, START, DATA, PARITY, STOP, CLEANUP, WAIT_HIGH.
- IDLE: when rx_s = 0, go to START with the counter cleared.
- START:
  - count to (CLKS_PER_BIT-1)/2, i.e. 43 at the default.
  - If rx_s is still 0, clear the counter and go to DATA.
  - If rx_s is 1, it is a glitch: return to IDLE, no pulse, no flags.
- DATA:
  - Each bit is sampled when the counter reaches CLKS_PER_BIT-1; the counter then clears.
  - Bit i goes into shift register position i. After DATA_BITS samples, go to PARITY if PARITY_MODE != 0, else go to STOP.
- PARITY:
  - Sample one bit at CLKS_PER_BIT-1.
  - Error when the XOR of data bits and the parity bit is 0 (odd mode) or 1 (even mode).
- STOP:
  - Sample STOP_BITS bits, each at CLKS_PER_BIT-1.
  - Any stop sample of 0 sets the frame error.
- CLEANUP, one cycle:
  - o_Rx_DV = 1; o_Rx_Byte, o_Parity_Err and o_Frame_Err update in this same cycle.
  - Data is delivered even when an error flag is set.
  - Next state is WAIT_HIGH if the frame error is set, else IDLE.
  - o_Rx_DV therefore rises exactly 1 cycle after the last stop-bit sample.
- WAIT_HIGH: stay until rx_s = 1, then go to IDLE. This prevents a held-low line from retriggering as a new start.
- o_Rx_Byte and the error flags hold their values until the next CLEANUP. o_Rx_DV is 0 in every other cycle.
- The receiver never back-pressures: o_Rx_DV is a pulse with no acknowledge, and the consumer must capture it in that cycle.
- Back-to-back frames: a new start edge arriving in the cycle after CLEANUP (now in IDLE) must be accepted.
- Counter width is $clog2(CLKS_PER_BIT). The counter never wraps beyond CLKS_PER_BIT-1.

Optional Feature:
Macro: UART_RX_BREAK_DET_EN.
- Defined:
  - o_Break exists.
  - It is set in CLEANUP when all data bits = 0, the parity bit (if any) = 0, and the frame error = 1.
  - It stays high through WAIT_HIGH and clears in the cycle rx_s returns to 1.
  - The character is still delivered: o_Rx_DV pulses, o_Rx_Byte = 0, o_Frame_Err = 1.
- Undefined: the o_Break port and its logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use a 10 MHz clock, CLKS_PER_BIT = 87 and a bit period of 8700 ns unless stated.
1. Defaults (8N1), send 0x3F then, with no idle gap, 0xA5 -> two o_Rx_DV pulses, bytes 0x3F then 0xA5, both error flags 0, o_Rx_Busy low after each stop bit.
2. DATA_BITS=7, PARITY_MODE=2: send 0x55 with parity bit 0 -> byte 0x55, o_Parity_Err 0. Then send 0x55 with parity bit 1 -> byte 0x55, o_Parity_Err 1, o_Rx_DV still pulses.
3. STOP_BITS=2, second stop bit driven low on character 0x81 -> byte 0x81, o_Frame_Err 1; FSM stays in WAIT_HIGH until the line goes high; the next 0x42 is received cleanly with o_Frame_Err 0.
4. Drive a 2000 ns low glitch on an idle line -> no o_Rx_DV; o_Rx_Busy pulses then returns to 0 within 50 cycles; the following 0x3C is received correctly.
5. Assert i_Reset for 3 cycles during data bit 3 of 0xFF -> all outputs 0 immediately, no o_Rx_DV; the following 0xA5 is received correctly.
6. UART_RX_BREAK_DET_EN defined, hold the line low for 12 bit periods -> one o_Rx_DV with byte 0x00 and o_Frame_Err 1; o_Break stays 1 until the line goes high, then 0; no second o_Rx_DV.
